controller_reader_8b: RTL and testbench
=======================================

CONTROLLER_READER_8B -- requirements
Module: controller_reader_8b

Interface
REQ-001 SHALL provide parameter LATCH_CYCLES, default 2, number of cycles pad_latch is held high (legal range >= 1).
REQ-002 SHALL provide parameter HALF_CYCLES, default 1, number of cycles in each high and low phase of pad_clock (legal range >= 1).
REQ-003 SHALL have a single clock and a synchronous active-high reset, named as in the rest of the codebase: clock  input  1  rising-edge system clock.
REQ-004 reset  input  1  synchronous, active-high, sampled on the rising edge of clock.
REQ-005 start  input  1  request a read; sampled only in IDLE and DONE.
REQ-006 serial_in  input  1  serial data bit from the pad shift register.
REQ-007 pad_latch  output  1  parallel-load strobe to the pad.
REQ-008 pad_clock  output  1  shift clock to the pad.
REQ-009 buttons  output  8  last completed byte; bit k is the k-th bit read.
REQ-010 busy  output  1  high while a read is in progress.
REQ-011 done  output  1  one-cycle pulse when buttons updates.

Function
REQ-012 SHALL implement the states IDLE, LATCH, SAMPLE, CLK_HI, CLK_LO and DONE, with all outputs registered.
REQ-013 IDLE: pad_latch=0, pad_clock=0, busy=0; start=1 -> LATCH, with the bit index cleared to 0.
REQ-014 LATCH: pad_latch=1, busy=1, held for exactly LATCH_CYCLES cycles, then -> SAMPLE.
REQ-015 SAMPLE: one cycle, pad_latch=0, pad_clock=0, busy=1; serial_in is captured into bit[index] at the end of the cycle.
REQ-016 SAMPLE with index<7 -> CLK_HI, and index increments.
REQ-017 SAMPLE with index==7 -> DONE, and buttons loads the assembled byte on the same edge.
REQ-018 CLK_HI: pad_clock=1 for HALF_CYCLES cycles, then -> CLK_LO.
REQ-019 CLK_LO: pad_clock=0 for HALF_CYCLES cycles, then -> SAMPLE.
REQ-020 DONE: one cycle, done=1, busy=0; start=1 -> LATCH (back-to-back read), otherwise -> IDLE.
REQ-021 A read SHALL produce exactly 7 pad_clock rising edges and 8 samples.
REQ-022 Latency SHALL be fixed: done is asserted in cycle LATCH_CYCLES + 8 + 14*HALF_CYCLES + 1 after the edge that accepts start (25 cycles with the defaults).
REQ-023 start SHALL be ignored in LATCH, SAMPLE, CLK_HI and CLK_LO.
REQ-024 buttons SHALL hold its value between reads and never show a partially assembled byte.

Reset
REQ-025 On reset=1 at a clock edge the block SHALL enter IDLE with pad_latch=0, pad_clock=0, busy=0, done=0, buttons=8'h00 and the bit index at 0.
REQ-026 Reset SHALL override start when both are asserted in the same cycle.
REQ-027 Reset asserted mid-read SHALL discard the partial byte, and the next start SHALL begin a complete new read.

Configuration
REQ-028 Macro CONTROLLER_READER_INVERT_EN, when defined, SHALL store the inverse of serial_in, so an active-low pad reads pressed=1.
REQ-029 Without CONTROLLER_READER_INVERT_EN, serial_in SHALL be stored unmodified; timing SHALL be identical in both builds.

Verification
REQ-030 Reset -> pad_latch=0, pad_clock=0, busy=0, done=0, buttons=8'h00.
REQ-031 Pad model loaded with 8'hA5 (bit0 first), one-cycle start, defaults -> pad_latch high in cycles 1-2, done in cycle 25, buttons=8'hA5 (8'h5A with the macro defined).
REQ-032 start held high for 40 cycles -> the first read completes in cycle 25, a second LATCH begins in cycle 26, and each read has exactly 7 pad_clock rising edges.
REQ-033 Reset asserted in cycle 10 of a read -> all outputs at reset values the next cycle, buttons=8'h00; a new start then returns the correct byte 8'h3C.
REQ-034 LATCH_CYCLES=3, HALF_CYCLES=2 with pad value 8'hFF -> done in cycle 40, buttons=8'hFF (8'h00 with the macro defined).

Source files
------------

// File: rtl/controller_reader_8b.sv
// Serial pad reader: latch pulse, then 8 samples and 7 shift clocks; done and buttons arrive LATCH_CYCLES+8+14*HALF_CYCLES+1 cycles after start.
// No backpressure: start is ignored mid-read. Define CONTROLLER_READER_INVERT_EN to store ~serial_in.
module controller_reader_8b #(
  parameter int LATCH_CYCLES = 2,
  parameter int HALF_CYCLES  = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       serial_in,
  output logic       pad_latch,
  output logic       pad_clock,
  output logic [7:0] buttons,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LATCH  = 3'd1;
  localparam logic [2:0] S_SAMPLE = 3'd2;
  localparam logic [2:0] S_CLK_HI = 3'd3;
  localparam logic [2:0] S_CLK_LO = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam int MAXC = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  logic [2:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [6:0]    data;
  logic          bit_in;

`ifdef CONTROLLER_READER_INVERT_EN
  assign bit_in = ~serial_in;
`else
  assign bit_in = serial_in;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = S_LATCH;
          cnt_nxt   = '0;
          idx_nxt   = 3'd0;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_LATCH: begin
        if (cnt == CW'(LATCH_CYCLES - 1)) begin
          state_nxt = S_SAMPLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_SAMPLE: begin
        if (idx == 3'd7) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_CLK_HI;
          idx_nxt   = idx + 3'd1;
          cnt_nxt   = '0;
        end
      end
      S_CLK_HI: begin
        if (cnt == CW'(HALF_CYCLES - 1)) begin
          state_nxt = S_CLK_LO;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_CLK_LO: begin
        if (cnt == CW'(HALF_CYCLES - 1)) begin
          state_nxt = S_SAMPLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet aligned with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= 3'd0;
      data      <= 7'd0;
      buttons   <= 8'h00;
      pad_latch <= 1'b0;
      pad_clock <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      pad_latch <= (state_nxt == S_LATCH);
      pad_clock <= (state_nxt == S_CLK_HI);
      busy      <= (state_nxt == S_LATCH) || (state_nxt == S_SAMPLE) ||
                   (state_nxt == S_CLK_HI) || (state_nxt == S_CLK_LO);
      done      <= (state_nxt == S_DONE);
      if (state == S_SAMPLE) begin
        if (idx != 3'd7) begin
          data[idx] <= bit_in;
        end else begin
          buttons <= {bit_in, data};
        end
      end
    end
  end

endmodule

// File: tb/tb_controller_reader_8b.sv
// Randomized bench for controller_reader_8b: two parameterizations, pad shift-register models and a cycle-position reference model.
module tb_controller_reader_8b;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] serial_in;
  logic [1:0] pad_latch, pad_clock, busy, done;
  logic [7:0] buttons [2];

  always #5 clock = ~clock;

  controller_reader_8b #(.LATCH_CYCLES(2), .HALF_CYCLES(1)) dut0 (
    .clock(clock), .reset(reset), .start(start), .serial_in(serial_in[0]),
    .pad_latch(pad_latch[0]), .pad_clock(pad_clock[0]), .buttons(buttons[0]),
    .busy(busy[0]), .done(done[0])
  );

  controller_reader_8b #(.LATCH_CYCLES(3), .HALF_CYCLES(2)) dut1 (
    .clock(clock), .reset(reset), .start(start), .serial_in(serial_in[1]),
    .pad_latch(pad_latch[1]), .pad_clock(pad_clock[1]), .buttons(buttons[1]),
    .busy(busy[1]), .done(done[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t: got %h expected %h", name, idx, $time, act, exp);
    end
  endtask

  function automatic int lc(input int i);
    return (i == 0) ? 2 : 3;
  endfunction

  function automatic int hc(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic int tot(input int i);
    return lc(i) + 8 + 14 * hc(i) + 1;
  endfunction

  function automatic logic [7:0] fix(input logic [7:0] v);
`ifdef CONTROLLER_READER_INVERT_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  // Expected outputs as a function of the cycle position r within a read (0 = idle).
  function automatic logic e_latch(input int r, input int i);
    return (r >= 1) && (r <= lc(i));
  endfunction

  function automatic logic e_busy(input int r, input int i);
    return (r >= 1) && (r < tot(i));
  endfunction

  function automatic logic e_clk(input int r, input int i);
    int p, per;
    p   = r - (lc(i) + 1);
    per = 1 + 2 * hc(i);
    if (r == 0 || p < 0 || r >= tot(i)) return 1'b0;
    return ((p % per) >= 1) && ((p % per) <= hc(i));
  endfunction

  // Pad: parallel load while latch is high, shift right on each pad_clock rise, bit0 first.
  logic [7:0] pad_val [2];
  logic [7:0] sh [2];
  logic       pclk_prev [2];

  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (pad_latch[i]) sh[i] <= pad_val[i];
      else if (pad_clock[i] && !pclk_prev[i]) sh[i] <= sh[i] >> 1;
      pclk_prev[i] <= pad_clock[i];
    end
  end

  assign serial_in[0] = sh[0][0];
  assign serial_in[1] = sh[1][0];

  // Reference model: position in the read, byte latched by the pad, last completed byte.
  int         rel [2];
  logic [7:0] cap [2];
  logic [7:0] ebtn [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      rel[i] = 0; cap[i] = 8'h00; ebtn[i] = 8'h00; sh[i] = 8'h00; pclk_prev[i] = 1'b0; pad_val[i] = 8'h00;
    end
  end

  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        rel[i]  = 0;
        ebtn[i] = 8'h00;
      end else if ((rel[i] == 0 || rel[i] == tot(i)) && start) begin
        rel[i] = 1;
      end else if (rel[i] == tot(i)) begin
        rel[i] = 0;
      end else if (rel[i] != 0) begin
        if (rel[i] == lc(i)) cap[i] = pad_val[i];
        rel[i]++;
        if (rel[i] == tot(i)) ebtn[i] = fix(cap[i]);
      end
    end
  end

  bit chk_en = 1'b0;
  int edges [2];
  logic pclk_neg_prev [2];

  always @(negedge clock) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check("pad_latch", i, {7'd0, pad_latch[i]}, {7'd0, e_latch(rel[i], i)});
        check("pad_clock", i, {7'd0, pad_clock[i]}, {7'd0, e_clk(rel[i], i)});
        check("busy", i, {7'd0, busy[i]}, {7'd0, e_busy(rel[i], i)});
        check("done", i, {7'd0, done[i]}, {7'd0, (rel[i] == tot(i))});
        check("buttons", i, buttons[i], ebtn[i]);
        if (rel[i] == 1) edges[i] = 0;
        if (pad_clock[i] && !pclk_neg_prev[i]) edges[i]++;
        if (done[i]) check("edges_per_read", i, 8'(edges[i]), 8'd7);
        pclk_neg_prev[i] = pad_clock[i];
      end
    end
  end

  int n, d0, d1;
  logic [7:0] b0, b1;

  initial begin
    edges[0] = 0; edges[1] = 0;
    pclk_neg_prev[0] = 1'b0; pclk_neg_prev[1] = 1'b0;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clock);
    chk_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check("rst_latch", i, {7'd0, pad_latch[i]}, 8'd0);
      check("rst_clock", i, {7'd0, pad_clock[i]}, 8'd0);
      check("rst_busy", i, {7'd0, busy[i]}, 8'd0);
      check("rst_done", i, {7'd0, done[i]}, 8'd0);
      check("rst_buttons", i, buttons[i], 8'h00);
    end
    reset = 1'b0;
    @(negedge clock);

    // Single read: A5 on the default block, FF on the slow one.
    pad_val[0] = 8'hA5; pad_val[1] = 8'hFF;
    start = 1'b1;
    n = 0; d0 = 0; d1 = 0; b0 = 8'h00; b1 = 8'h00;
    while (n < 100 && (d0 == 0 || d1 == 0)) begin
      @(negedge clock);
      n++;
      if (n == 1) start = 1'b0;
      if (n <= 3) check("latch_window", 0, {7'd0, pad_latch[0]}, (n <= 2) ? 8'd1 : 8'd0);
      if (done[0] && d0 == 0) begin d0 = n; b0 = buttons[0]; end
      if (done[1] && d1 == 0) begin d1 = n; b1 = buttons[1]; end
    end
    check("done_cycle", 0, 8'(d0), 8'd25);
    check("done_cycle", 1, 8'(d1), 8'd40);
`ifdef CONTROLLER_READER_INVERT_EN
    check("byte_a5", 0, b0, 8'h5A);
    check("byte_ff", 1, b1, 8'h00);
`else
    check("byte_a5", 0, b0, 8'hA5);
    check("byte_ff", 1, b1, 8'hFF);
`endif
    repeat (3) @(negedge clock);

    // start held high: back-to-back reads.
    pad_val[0] = 8'h96; pad_val[1] = 8'h1E;
    start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (k == 25) check("b2b_done", 0, {7'd0, done[0]}, 8'd1);
      if (k == 26) check("b2b_relatch", 0, {7'd0, pad_latch[0]}, 8'd1);
      if (k == 40) start = 1'b0;
    end
    repeat (60) @(negedge clock);

    // Reset in cycle 10 of a read, then a clean read of 3C.
    pad_val[0] = 8'h3C; pad_val[1] = 8'h3C;
    start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (k == 1) start = 1'b0;
      if (k == 10) reset = 1'b1;
    end
    @(negedge clock);
    check("midrst_buttons", 0, buttons[0], 8'h00);
    check("midrst_busy", 0, {7'd0, busy[0]}, 8'd0);
    check("midrst_latch", 0, {7'd0, pad_latch[0]}, 8'd0);
    reset = 1'b0;
    start = 1'b1;
    n = 0; d0 = 0; b0 = 8'h00;
    while (n < 100 && d0 == 0) begin
      @(negedge clock);
      n++;
      if (n == 1) start = 1'b0;
      if (done[0]) begin d0 = n; b0 = buttons[0]; end
    end
    check("rerun_cycle", 0, 8'(d0), 8'd25);
    check("byte_3c", 0, b0, fix(8'h3C));
    repeat (50) @(negedge clock);

    // Random start / reset / pad contents.
    for (int k = 0; k < 4000; k++) begin
      @(negedge clock);
      start = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < 2; i++)
        if ($urandom_range(0, 19) == 0) pad_val[i] = 8'($urandom);
    end
    reset = 1'b0;
    start = 1'b0;
    repeat (60) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
